// File: rtl/sha256_blk_ctrl.sv
// sha256_blk_ctrl: block sequencer for an iterative (one round per clock)
// SHA-256 compression core. Accepts padded 512-bit blocks, runs the core
// through load / ROUNDS rounds / H update, chains blocks of one message and
// presents the final digest to the consumer until it is taken.
module sha256_blk_ctrl #(
    parameter  int unsigned ROUNDS = 64,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned RND_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    input  logic             blk_last,
    input  logic             abort,
    output logic [511:0]     core_msg,
    output logic             core_load,
    output logic             core_init,
    output logic             core_en,
    output logic [RND_W-1:0] core_round,
    output logic             core_update,
    output logic             digest_valid,
    input  logic             digest_ready,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROUND  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(ROUNDS - 1);

    state_t             r_state;
    logic               r_first;      // next block starts a new message (a..h from IV)
    logic               r_last;       // block in flight is the last of its message
    logic [CNT_W-1:0]   r_count;
    logic [511:0]       r_msg;
    logic [RND_W-1:0]   r_round;
    logic               r_blk_ready;
    logic               r_load;
    logic               r_init;
    logic               r_en;
    logic               r_update;
    logic               r_dvalid;

    logic               w_accept;
    logic               w_round_end;
    logic [CNT_W-1:0]   w_count_inc;

    // Block handshake, last-round detect and saturating block counter increment
    assign w_accept    = blk_valid && r_blk_ready;
    assign w_round_end = (r_round == LAST_ROUND);
    assign w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);

    // Sequencer: state plus every registered output, reset and abort first
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_first     <= 1'b1;
            r_last      <= 1'b0;
            r_count     <= '0;
            r_msg       <= '0;
            r_round     <= '0;
            r_blk_ready <= 1'b1;
            r_load      <= 1'b0;
            r_init      <= 1'b0;
            r_en        <= 1'b0;
            r_update    <= 1'b0;
            r_dvalid    <= 1'b0;
        end else if (abort) begin
            // Drop the message: the captured block stays but is never used
            r_state     <= ST_IDLE;
            r_first     <= 1'b1;
            r_count     <= '0;
            r_round     <= '0;
            r_blk_ready <= 1'b1;
            r_load      <= 1'b0;
            r_init      <= 1'b0;
            r_en        <= 1'b0;
            r_update    <= 1'b0;
            r_dvalid    <= 1'b0;
        end else begin
            // Single-cycle strobes default low
            r_load   <= 1'b0;
            r_update <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_msg       <= blk_data;
                        r_last      <= blk_last;
                        r_count     <= w_count_inc;
                        r_init      <= r_first;
                        r_load      <= 1'b1;
                        r_round     <= '0;
                        r_blk_ready <= 1'b0;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_round <= '0;
                    r_init  <= 1'b0;
                    r_en    <= 1'b1;
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (w_round_end) begin
                        r_en     <= 1'b0;
                        r_round  <= '0;
                        r_update <= 1'b1;
                        r_state  <= ST_UPDATE;
                    end else begin
                        r_round <= r_round + RND_W'(1);
                    end
                end
                ST_UPDATE: begin
                    // H now holds chained state; later blocks start from it
                    r_first <= 1'b0;
                    if (r_last) begin
                        r_dvalid <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_blk_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    // Digest held until the consumer takes it
                    if (digest_ready) begin
                        r_dvalid    <= 1'b0;
                        r_blk_ready <= 1'b1;
                        r_first     <= 1'b1;
                        r_count     <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_blk_ready <= 1'b1;
                    r_en        <= 1'b0;
                    r_dvalid    <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; busy is a pure state decode
    assign blk_ready    = r_blk_ready;
    assign core_msg     = r_msg;
    assign core_load    = r_load;
    assign core_init    = r_init;
    assign core_en      = r_en;
    assign core_round   = r_round;
    assign core_update  = r_update;
    assign digest_valid = r_dvalid;
    assign blk_count    = r_count;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sha256_blk_ctrl.sv
// tb_sha256_blk_ctrl: random and directed stimulus for sha256_blk_ctrl.
// Expected control timing comes from a latency model (cycles since block
// acceptance); a behavioural SHA-256 core driven by the DUT strobes is
// compared against a whole-message reference hash and known answers.
module tb_sha256_blk_ctrl;

    localparam int unsigned ROUNDS  = 64;
    localparam int unsigned CNT_W   = 16;
    localparam int          PH_LOAD = 1;
    localparam int          PH_UPD  = ROUNDS + 2;
    localparam int          PH_DONE = ROUNDS + 3;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_M1  =
        512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000;
    localparam logic [511:0] BLK_M2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_M   =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic              clk = 1'b0;
    logic              rst, blk_valid, blk_last, abort, digest_ready;
    logic [511:0]      blk_data;
    logic              blk_ready, core_load, core_init, core_en, core_update;
    logic              digest_valid, busy;
    logic [511:0]      core_msg;
    logic [5:0]        core_round;
    logic [CNT_W-1:0]  blk_count;

    always #5 clk = ~clk;

    sha256_blk_ctrl #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_data     (blk_data),
        .blk_last     (blk_last),
        .abort        (abort),
        .core_msg     (core_msg),
        .core_load    (core_load),
        .core_init    (core_init),
        .core_en      (core_en),
        .core_round   (core_round),
        .core_update  (core_update),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .busy         (busy),
        .blk_count    (blk_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- SHA-256 arithmetic ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sched(input logic [31:0] w2, input logic [31:0] w7,
                                          input logic [31:0] w15, input logic [31:0] w16);
        logic [31:0] s0, s1;
        s0 = rotr(w15, 7) ^ rotr(w15, 18) ^ (w15 >> 3);
        s1 = rotr(w2, 17) ^ rotr(w2, 19) ^ (w2 >> 10);
        return w16 + s0 + w7 + s1;
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] w,
                                               input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [255:0] s;
        s = hin;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) w[t] = sched(w[t-2], w[t-7], w[t-15], w[t-16]);
        for (int t = 0; t < 64; t++) s = sha_round(s, w[t], K[t]);
        return add8(hin, s);
    endfunction

    // ---------------- behavioural core driven by the DUT strobes ----------------
    logic [31:0]  c_w [64];
    logic [255:0] c_s, c_h;
    logic         c_first;

    always @(posedge clk) begin : core_mdl
        int          t;
        logic [31:0] wt;
        if (core_load) begin
            for (int i = 0; i < 16; i++) c_w[i] <= core_msg[511 - 32*i -: 32];
            c_s     <= core_init ? IV : c_h;
            c_first <= core_init;
        end else if (core_en) begin
            t = int'(core_round);
            if (t < 16) wt = c_w[t];
            else        wt = sched(c_w[t-2], c_w[t-7], c_w[t-15], c_w[t-16]);
            c_w[t] <= wt;
            c_s    <= sha_round(c_s, wt, K[t]);
        end
        if (core_update) c_h <= add8(c_first ? IV : c_h, c_s);
    end

    // ---------------- latency reference model ----------------
    // ph = cycles since the block was accepted (0 = idle, accepting)
    int               ph      = 0;
    logic             m_first = 1'b1;
    logic             m_last  = 1'b0;
    logic [CNT_W-1:0] m_cnt   = '0;
    logic [511:0]     m_msg   = '0;
    logic [511:0]     msgq [$];
    bit               dig_checked = 1'b0;
    bit               known_en    = 1'b0;
    logic [255:0]     known_dig   = '0;

    function automatic logic [255:0] sha_ref();
        logic [255:0] h;
        h = IV;
        foreach (msgq[i]) h = compress(h, msgq[i]);
        return h;
    endfunction

    task automatic model_step();
        if (!rst || abort) begin
            ph = 0; m_first = 1'b1; m_cnt = '0; msgq.delete();
        end else if (ph == 0) begin
            if (blk_valid) begin
                ph     = PH_LOAD;
                m_cnt  = (m_cnt == {CNT_W{1'b1}}) ? m_cnt : m_cnt + 1'b1;
                m_last = blk_last;
                m_msg  = blk_data;
                msgq.push_back(blk_data);
            end
        end else if (ph < PH_UPD) begin
            ph++;
        end else if (ph == PH_UPD) begin
            m_first = 1'b0;
            if (m_last) begin ph = PH_DONE; dig_checked = 1'b0; end
            else ph = 0;
        end else if (digest_ready) begin
            ph = 0; m_first = 1'b1; m_cnt = '0; msgq.delete();
        end
    endtask

    function automatic logic [28:0] exp_vec();
        logic       en;
        logic [5:0] rnd;
        en  = (ph >= 2) && (ph <= PH_UPD - 1);
        rnd = en ? 6'(ph - 2) : 6'd0;
        return {ph == 0, ph == PH_LOAD, (ph == PH_LOAD) && m_first, en, rnd,
                ph == PH_UPD, ph == PH_DONE, ph != 0, m_cnt};
    endfunction

    function automatic logic [28:0] dut_vec();
        return {blk_ready, core_load, core_load & core_init, core_en,
                core_en ? core_round : 6'd0, core_update, digest_valid, busy, blk_count};
    endfunction

    // One clock: advance the model on the current inputs, then compare
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("ctrl", 512'(dut_vec()), 512'(exp_vec()));
        if (ph == PH_LOAD) check_eq("core_msg", core_msg, m_msg);
        if (ph == PH_DONE && !dig_checked) begin
            dig_checked = 1'b1;
            check_eq("digest", 512'(c_h), 512'(sha_ref()));
            if (known_en) begin
                check_eq("digest_kat", 512'(c_h), 512'(known_dig));
                known_en = 1'b0;
            end
        end
    endtask

    task automatic send_block(input logic [511:0] d, input bit last);
        int guard;
        guard     = 0;
        blk_data  = d;
        blk_last  = last;
        blk_valid = 1'b1;
        do begin
            tick();
            guard++;
        end while (ph != PH_LOAD && guard < 50);
        blk_valid = 1'b0;
        check_eq("accept_in_time", 512'(guard < 50), 512'(1));
    endtask

    task automatic run_block(input bit toggle, input int dr_delay, input int abort_ph,
                             input bit rnd_dr, output bit aborted);
        int guard, done_cnt;
        guard    = 0;
        done_cnt = 0;
        aborted  = 1'b0;
        while (ph != 0 && guard < 400) begin
            blk_valid = (toggle && ph >= 2 && ph <= PH_UPD) ? ~blk_valid : 1'b0;
            if (ph == PH_DONE) begin
                digest_ready = (done_cnt >= dr_delay);
                done_cnt++;
            end else begin
                digest_ready = rnd_dr ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            abort = (abort_ph != 0) && (ph == abort_ph);
            if (abort) aborted = 1'b1;
            tick();
            guard++;
        end
        abort        = 1'b0;
        blk_valid    = 1'b0;
        digest_ready = 1'b0;
        check_eq("block_finished", 512'(guard < 400), 512'(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            digest_ready = 1'($urandom_range(0, 1));
            tick();
        end
        digest_ready = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bit           ab, tg;
        int           nb, aph, drd;
        logic [511:0] d;

        rst = 1'b0; blk_valid = 1'b0; blk_last = 1'b0; abort = 1'b0;
        digest_ready = 1'b0; blk_data = '0;
        tick();
        tick();
        check_eq("reset_core_msg", core_msg, 512'(0));
        rst = 1'b1;
        tick();

        // Single block "abc"
        known_dig = DIG_ABC; known_en = 1'b1;
        send_block(BLK_ABC, 1'b1);
        run_block(1'b0, 0, 0, 1'b0, ab);

        // Two-block message, chained H
        send_block(BLK_M1, 1'b0);
        run_block(1'b0, 0, 0, 1'b0, ab);
        known_dig = DIG_M; known_en = 1'b1;
        send_block(BLK_M2, 1'b1);
        run_block(1'b0, 0, 0, 1'b0, ab);

        // Digest backpressure for 10 cycles
        known_dig = DIG_ABC; known_en = 1'b1;
        send_block(BLK_ABC, 1'b1);
        run_block(1'b0, 10, 0, 1'b0, ab);

        // Abort at round 30 of a last block, then a fresh message
        send_block(BLK_M2, 1'b1);
        run_block(1'b0, 0, 2 + 30, 1'b0, ab);
        check_eq("abort_taken", 512'(ab), 512'(1));
        blk_valid = 1'b1; abort = 1'b1; blk_data = BLK_M1;
        tick();
        abort = 1'b0; blk_valid = 1'b0;
        known_dig = DIG_ABC; known_en = 1'b1;
        send_block(BLK_ABC, 1'b1);
        run_block(1'b0, 0, 0, 1'b0, ab);

        // Reset mid-round with blk_valid held high
        send_block(BLK_M1, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b0; blk_valid = 1'b1; blk_data = BLK_ABC; blk_last = 1'b1;
        tick();
        check_eq("midrst_core_msg", core_msg, 512'(0));
        rst = 1'b1;
        known_dig = DIG_ABC; known_en = 1'b1;
        tick();
        blk_valid = 1'b0;
        run_block(1'b0, 0, 0, 1'b0, ab);

        // blk_valid toggling while busy
        send_block(BLK_M1, 1'b0);
        run_block(1'b1, 0, 0, 1'b0, ab);
        known_dig = DIG_M; known_en = 1'b1;
        send_block(BLK_M2, 1'b1);
        run_block(1'b1, 2, 0, 1'b0, ab);

        // Random messages
        for (int m = 0; m < 24; m++) begin
            nb = $urandom_range(1, 3);
            tg = 1'($urandom_range(0, 1));
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < 16; k++) d[511 - 32*k -: 32] = $urandom();
                aph = ($urandom_range(0, 7) == 0) ? $urandom_range(1, PH_DONE) : 0;
                drd = $urandom_range(0, 4);
                send_block(d, b == nb - 1);
                run_block(tg, drd, aph, 1'b1, ab);
                if (ab) break;
                idle($urandom_range(0, 2));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
